// File: rtl/uart_tx_ctrl.sv
// UART transmitter with a byte FIFO in front of an 8N1 framing FSM.
// Bit timing comes from a divisor latched at the start of each frame.
module uart_tx_ctrl #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  input  logic [DIV_WIDTH-1:0]          baud_div,
  input  logic                          tx_enable,
  output logic                          tx,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          busy,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [7:0]           shift_q, shift_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic                 tx_q, tx_d;
  logic                 overflow_q, overflow_d;

  logic [7:0]           mem [FIFO_DEPTH];
  logic                 wr_accept;
  logic                 bit_end;
  logic                 pop;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count     = wr_ptr_q - rd_ptr_q;
  assign wr_accept = wr_en && !full;
  assign bit_end   = (baud_cnt_q == div_q);
  // A new frame may only start from IDLE or exactly at the end of a stop bit.
  assign pop       = tx_enable && !empty &&
                     ((state_q == IDLE) || ((state_q == STOP) && bit_end));

  assign tx       = tx_q;
  assign busy     = (state_q != IDLE);
  assign overflow = overflow_q;

  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    shift_d    = shift_q;
    div_d      = div_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    overflow_d = wr_en && full;

    if (wr_accept) wr_ptr_d = wr_ptr_q + PW'(1);

    case (state_q)
      IDLE: baud_cnt_d = '0;
      START: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          state_d    = DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + DIV_WIDTH'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          shift_d    = shift_q >> 1;
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = 3'd0;
            state_d   = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + DIV_WIDTH'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          state_d    = IDLE;
        end else begin
          baud_cnt_d = baud_cnt_q + DIV_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      state_d    = START;
      shift_d    = mem[rd_ptr_q[AW-1:0]];
      div_d      = baud_div;
      baud_cnt_d = '0;
      bit_idx_d  = 3'd0;
      rd_ptr_d   = rd_ptr_q + PW'(1);
    end

    // tx follows the next state so the line changes on the same edge as the FSM.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      shift_q    <= '0;
      div_q      <= '0;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      shift_q    <= shift_d;
      div_q      <= div_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: a line monitor decodes frames and checks
// them against a queue of bytes pushed as they are written.
module tb_uart_tx_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic [15:0] baud_div = 16'd3;
  logic        tx_enable = 1'b0;
  logic        tx, full, empty, busy, overflow;
  logic [4:0]  count;

  int total = 0;
  int bad = 0;

  logic [7:0] sb_q[$];
  bit         exp_wave[$];
  int         line_div = 3;
  int         frames_rx = 0;
  int         ovf_cycles = 0;
  int         max_cnt = 0;
  logic       track_en = 1'b0;
  logic       mon_busy = 1'b0;
  int         mon_cyc = 0;
  logic [7:0] mon_byte = 8'h00;

  uart_tx_ctrl #(.FIFO_DEPTH(16), .DIV_WIDTH(16)) dut (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_data(wr_data),
    .baud_div(baud_div), .tx_enable(tx_enable), .tx(tx), .full(full),
    .empty(empty), .count(count), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit accept);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = b;
    if (accept) sb_q.push_back(b);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  function automatic void pushFrame(input logic [7:0] b, input int p);
    for (int j = 0; j < p; j++) exp_wave.push_back(1'b0);
    for (int k = 0; k < 8; k++)
      for (int j = 0; j < p; j++) exp_wave.push_back(b[k]);
    for (int j = 0; j < p; j++) exp_wave.push_back(1'b1);
  endfunction

  task automatic waitBusy(input string tag, input logic val, input int limit);
    logic got = 1'b0;
    for (int i = 0; i < limit && !got; i++) begin
      @(negedge clk);
      if (busy === val) got = 1'b1;
    end
    checkOutput(tag, 32'(got), 32'd1);
  endtask

  task automatic waitDrain(input string tag, input int limit);
    logic got = 1'b0;
    for (int i = 0; i < limit && !got; i++) begin
      @(negedge clk);
      if (empty === 1'b1 && busy === 1'b0) got = 1'b1;
    end
    checkOutput(tag, 32'(got), 32'd1);
  endtask

  // Compares tx cycle by cycle against exp_wave; optionally rewrites baud_div mid-frame.
  task automatic checkWave(input string tag, input int chg_at, input logic [15:0] chg_val);
    int   errs = 0;
    int   n;
    logic got = 1'b0;
    n = exp_wave.size();
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (busy === 1'b1) got = 1'b1;
    end
    checkOutput({tag, "_start"}, 32'(got), 32'd1);
    if (got) begin
      for (int i = 0; i < n; i++) begin
        if (i > 0) @(negedge clk);
        if (i == chg_at) baud_div = chg_val;
        if (tx !== exp_wave[i] || busy !== 1'b1) errs++;
      end
      checkOutput({tag, "_wave_errors"}, 32'(errs), 32'd0);
      @(negedge clk);
      checkOutput({tag, "_busy_after"}, 32'(busy), 32'd0);
      checkOutput({tag, "_empty_after"}, 32'(empty), 32'd1);
      checkOutput({tag, "_tx_after"}, 32'(tx), 32'd1);
    end
    exp_wave.delete();
  endtask

  // Line monitor: samples the first cycle of each bit after a falling start edge.
  always @(negedge clk) begin
    int k;
    if (overflow === 1'b1) ovf_cycles++;
    if (track_en && int'(count) > max_cnt) max_cnt = int'(count);
    if (rstn !== 1'b1) begin
      mon_busy = 1'b0;
    end else if (!mon_busy) begin
      if (tx === 1'b0) begin
        mon_busy = 1'b1;
        mon_cyc  = 0;
      end
    end else begin
      mon_cyc++;
      if (mon_cyc % (line_div + 1) == 0) begin
        k = mon_cyc / (line_div + 1);
        if (k >= 1 && k <= 8) begin
          mon_byte = {tx, mon_byte[7:1]};
        end else if (k == 9) begin
          checkOutput("stop_bit", 32'(tx), 32'd1);
          if (sb_q.size() == 0) checkOutput("frame_was_expected", 32'(sb_q.size() != 0), 32'd1);
          else checkOutput("rx_byte", 32'(mon_byte), 32'(sb_q.pop_front()));
          frames_rx++;
          mon_busy = 1'b0;
        end
      end
    end
  end

  initial begin
    int f0;
    int errs;

    @(negedge clk);
    checkOutput("reset_tx", 32'(tx), 32'd1);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_empty", 32'(empty), 32'd1);
    checkOutput("reset_full", 32'(full), 32'd0);
    checkOutput("reset_count", 32'(count), 32'd0);
    checkOutput("reset_overflow", 32'(overflow), 32'd0);
    rstn = 1'b1;

    $display("[TB] single frame 0xA5, baud_div=3, divisor changed mid-frame");
    tx_enable = 1'b1;
    pushFrame(8'hA5, 4);
    applyStimulus(8'hA5, 1'b1);
    checkWave("single", 6, 16'd9);
    baud_div = 16'd3;

    $display("[TB] fill with 17 bytes, baud_div=0");
    tx_enable = 1'b0;
    baud_div  = 16'd0;
    line_div  = 0;
    for (int i = 0; i < 16; i++) applyStimulus(8'(i * 13 + 1), 1'b1);
    checkOutput("fill_full", 32'(full), 32'd1);
    checkOutput("fill_count", 32'(count), 32'd16);
    checkOutput("fill_overflow_idle", 32'(overflow), 32'd0);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = 8'hEE;
    @(negedge clk);
    wr_en = 1'b0;
    checkOutput("ovf_pulse", 32'(overflow), 32'd1);
    checkOutput("ovf_count", 32'(count), 32'd16);
    @(negedge clk);
    checkOutput("ovf_pulse_end", 32'(overflow), 32'd0);
    checkOutput("ovf_count_after", 32'(count), 32'd16);
    checkOutput("ovf_cycles_fill", 32'(ovf_cycles), 32'd1);
    f0 = frames_rx;
    tx_enable = 1'b1;
    waitDrain("fill_drain", 400);
    checkOutput("fill_frames", 32'(frames_rx - f0), 32'd16);
    checkOutput("fill_sb_left", 32'(sb_q.size()), 32'd0);

    $display("[TB] back-to-back 0x00, 0xFF at baud_div=1");
    tx_enable = 1'b0;
    baud_div  = 16'd1;
    line_div  = 1;
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'hFF, 1'b1);
    pushFrame(8'h00, 2);
    pushFrame(8'hFF, 2);
    @(negedge clk);
    tx_enable = 1'b1;
    checkWave("b2b", -1, 16'd0);

    $display("[TB] wrap: 40 bytes streamed in bursts");
    baud_div = 16'd0;
    line_div = 0;
    max_cnt  = 0;
    track_en = 1'b1;
    f0 = frames_rx;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(8'(i * 7 + 3), 1'b1);
      if (i % 3 == 2) repeat (35) @(negedge clk);
    end
    waitDrain("wrap_drain", 1000);
    track_en = 1'b0;
    checkOutput("wrap_frames", 32'(frames_rx - f0), 32'd40);
    checkOutput("wrap_sb_left", 32'(sb_q.size()), 32'd0);
    checkOutput("wrap_max_count_le_16", 32'(max_cnt <= 16), 32'd1);
    checkOutput("wrap_no_overflow", 32'(ovf_cycles), 32'd1);

    $display("[TB] enable gating with 3 queued bytes");
    tx_enable = 1'b0;
    baud_div  = 16'd1;
    line_div  = 1;
    applyStimulus(8'hA1, 1'b1);
    applyStimulus(8'hB2, 1'b1);
    applyStimulus(8'hC3, 1'b1);
    f0 = frames_rx;
    @(negedge clk);
    tx_enable = 1'b1;
    waitBusy("gate_start", 1'b1, 20);
    repeat (3) @(negedge clk);
    tx_enable = 1'b0;
    waitBusy("gate_idle", 1'b0, 100);
    checkOutput("gate_count", 32'(count), 32'd2);
    repeat (30) @(negedge clk);
    checkOutput("gate_still_idle", 32'(busy), 32'd0);
    checkOutput("gate_count_hold", 32'(count), 32'd2);
    checkOutput("gate_frames", 32'(frames_rx - f0), 32'd1);
    tx_enable = 1'b1;
    waitDrain("gate_drain", 200);
    checkOutput("gate_frames_all", 32'(frames_rx - f0), 32'd3);
    checkOutput("gate_sb_left", 32'(sb_q.size()), 32'd0);

    $display("[TB] reset during DATA bit 3 of 0x55");
    baud_div = 16'd3;
    line_div = 3;
    applyStimulus(8'h55, 1'b1);
    waitBusy("rst_start", 1'b1, 20);
    repeat (17) @(negedge clk);
    checkOutput("rst_bit3_low", 32'(tx), 32'd0);
    rstn = 1'b0;
    sb_q.delete();
    #1;
    checkOutput("rst_tx_high", 32'(tx), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_empty", 32'(empty), 32'd1);
    checkOutput("rst_count", 32'(count), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    f0 = frames_rx;
    errs = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) errs++;
    end
    checkOutput("rst_line_quiet", 32'(errs), 32'd0);
    checkOutput("rst_empty_after", 32'(empty), 32'd1);
    checkOutput("rst_busy_after", 32'(busy), 32'd0);
    checkOutput("rst_no_frame", 32'(frames_rx - f0), 32'd0);

    checkOutput("total_overflow_cycles", 32'(ovf_cycles), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 Parameter: FIFO_DEPTH, 16, TX buffer entries; power of two, 4 to 256.
REQ-002 Parameter: DIV_WIDTH, 16, width of the baud divisor.
REQ-003 Port: clk  input  1  system clock; all logic on the rising edge.
REQ-004 Port: rstn  input  1  reset, asynchronous, active-low.
REQ-005 Port: wr_en  input  1  push request for wr_data, from the APB register write.
REQ-006 Port: wr_data  input  8  byte to transmit.
REQ-007 Port: baud_div  input  DIV_WIDTH  bit period minus one, in clk cycles.
REQ-008 Port: tx_enable  input  1  permits the start of new frames.
REQ-009 Port: tx  output  1  serial line, registered, idle high.
REQ-010 Port: full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-011 Port: empty  output  1  FIFO holds 0 entries.
REQ-012 Port: count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-013 Port: busy  output  1  high whenever the FSM is not in IDLE.
REQ-014 Port: overflow  output  1  one-cycle pulse when a write is dropped.

Function
REQ-015 FIFO pointers SHALL be $clog2(FIFO_DEPTH)+1 bits wide; the MSB is the wrap bit.
REQ-016 empty SHALL be high when the pointers are equal; full SHALL be high when the MSBs differ and the low bits are equal.
REQ-017 A write SHALL be accepted only when wr_en=1 and full=0 in the same cycle, even if a pop occurs in that cycle.
REQ-018 When wr_en=1 and full=1, the byte SHALL be discarded, overflow SHALL pulse high for exactly one cycle, and pointers SHALL be unchanged.
REQ-019 count SHALL equal wr_ptr-wr... 

Correction, REQ-019 count SHALL equal wr_ptr minus rd_ptr, modulo 2^(PTR width).
- Simultaneous accepted write and pop: count unchanged.
REQ-020 The FSM SHALL have four states: IDLE, START, DATA, STOP.
REQ-021 IDLE -> START SHALL occur when tx_enable=1 and empty=0. On that edge:
- pop one byte into the 8-bit shift register
- latch baud_div
- clear the baud counter and bit index
REQ-022 tx SHALL be 0 during START, shift-register bit[0] during DATA (LSB first), and 1 during STOP and IDLE.
REQ-023 Each state SHALL last exactly latched_baud_div+1 cycles, timed by a counter that runs from 0 to latched_baud_div.
REQ-024 START SHALL move to DATA after one bit period.
REQ-025 DATA SHALL shift right once per bit period and move to STOP after 8 bits; the bit index runs 0..7.
REQ-026 At the end of STOP:
- if tx_enable=1 and empty=0, pop the next byte and go directly to START, with no idle cycle between frames
- otherwise go to IDLE
REQ-027 The first START cycle of a frame SHALL appear on tx one cycle after the pop edge; tx SHALL be registered.
REQ-028 Changes to baud_div during a frame SHALL NOT affect that frame.
REQ-029 Deasserting tx_enable mid-frame SHALL let the current frame complete; no further pop SHALL occur.
REQ-030 baud_div=0 SHALL give 1-cycle bits.
REQ-031 Pointer wrap-around SHALL preserve byte order indefinitely.

Reset
REQ-032 With rstn=0, asynchronously:
- pointers 0, count 0, empty=1, full=0
- tx=1, busy=0, overflow=0
- state IDLE, shift register and counters 0
REQ-033 Reset mid-frame SHALL abort the frame: tx returns high immediately, and all buffered bytes are discarded.
REQ-034 FIFO memory contents SHALL NOT require reset.

Verification
REQ-035 Single frame: baud_div=3, tx_enable=1, write 0xA5.
- tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total)
- busy high for 40 cycles, then empty=1
REQ-036 Fill: tx_enable=0, write 17 bytes.
- after the 16th write: full=1, count=16
- 17th write: overflow high for 1 cycle, count stays 16
- then tx_enable=1: the first 16 bytes are sent in order
REQ-037 Back-to-back: baud_div=1, write 0x00 and 0xFF.
- 40 contiguous cycles: stop bit of frame 1 followed immediately by start bit of frame 2
- no extra high cycle between frames
REQ-038 Wrap: stream 40 bytes with an interleaved write pattern.
- all 40 received in order by a bench UART monitor
- count never exceeds 16, no overflow
REQ-039 Reset mid-frame: assert rstn=0 during the DATA bit 3 of 0x55.
- tx=1 within the same cycle
- after release: empty=1, busy=0, no frame emitted
REQ-040 Enable gating: clear tx_enable during frame 1 of 3 queued bytes.
- frame 1 completes, then IDLE with count=2
- re-enabling sends the remaining 2 bytes
